serial_parity_checker: RTL and testbench

//  Receive-side partner of the serial even/odd parity generator. Deserialises a framed
//  bit stream of DATA_W data bits (LSB first) followed by one parity bit.

---
 rtl/serial_parity_checker.sv | 108 ++++++++++
 tb/tb_serial_parity_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_checker.sv
// Receive-side serial parity checker: deserialises LSB-first frames of DATA_W bits plus
// one parity bit, flags parity/framing errors and keeps a saturating parity-error count.
module serial_parity_checker #(
   parameter int DATA_W     = 8,
   parameter int PARITY_ODD = 0,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 x,
   input  logic                 x_valid,
   input  logic                 sof,
   output logic [DATA_W-1:0]    data_out,
   output logic                 data_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
   localparam logic ODD_BIT = 1'(PARITY_ODD);

   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              par;
   logic [DATA_W-1:0] sreg;
   logic              start, shift, done, restart, bad_par;

   // New bit enters at the MSB so the first data bit lands in bit 0 after DATA_W shifts.
   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
      logic [DATA_W-1:0] r;
      r = v >> 1;
      r[DATA_W-1] = b;
      return r;
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      return (c == '1) ? c : c + ERR_CNT_W'(1);
   endfunction

   assign bad_par = ((par ^ x) != ODD_BIT);
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      shift     = 1'b0;
      done      = 1'b0;
      restart   = 1'b0;
      if (x_valid) begin
         if (sof) begin
            // sof always starts a new frame; mid-frame it also drops the old one.
            start     = 1'b1;
            restart   = (state != IDLE);
            state_nxt = (DATA_W == 1) ? PARITY : DATA;
         end else begin
            case (state)
               DATA: begin
                  shift = 1'b1;
                  if (cnt == LAST_IDX) state_nxt = PARITY;
               end
               PARITY: begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end
               default: state_nxt = state;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         par        <= 1'b0;
         sreg       <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         err_count  <= '0;
      end else begin
         state      <= state_nxt;
         data_valid <= done;
         parity_err <= done && bad_par;
         frame_err  <= restart;
         if (start) begin
            sreg <= shift_in('0, x);
            par  <= x;
            cnt  <= CNT_W'(1);
         end else if (shift) begin
            sreg <= shift_in(sreg, x);
            par  <= par ^ x;
            cnt  <= cnt + CNT_W'(1);
         end
         if (done) begin
            data_out <= sreg;
            if (bad_par) err_count <= sat_inc(err_count);
         end
      end
   end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: an even/8-bit counter instance and an odd/2-bit counter
// instance share one randomized bit stream; each is compared to a word-level model every cycle.
module tb_serial_parity_checker;

   logic clk = 1'b0;
   logic rst, x, x_valid, sof;
   logic [7:0] dout0, dout1;
   logic dv0, dv1, pe0, pe1, fe0, fe1, busy0, busy1;
   logic [7:0] cnt0;
   logic [1:0] cnt1;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;
   int fe_seen = 0;

   // model state, index 0: even parity / 8-bit counter, index 1: odd parity / 2-bit counter
   bit in_frame[2];
   int nbits[2], word[2], ones[2];
   int exp_data[2], exp_cnt[2];
   bit exp_dv[2], exp_pe[2], exp_fe[2];
   int max_cnt[2] = '{255, 3};
   int odd_mode[2] = '{0, 1};

   always #5 clk = ~clk;

   serial_parity_checker #(.DATA_W(8), .PARITY_ODD(0), .ERR_CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sof(sof),
      .data_out(dout0), .data_valid(dv0), .parity_err(pe0), .frame_err(fe0),
      .busy(busy0), .err_count(cnt0));

   serial_parity_checker #(.DATA_W(8), .PARITY_ODD(1), .ERR_CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .sof(sof),
      .data_out(dout1), .data_valid(dv1), .parity_err(pe1), .frame_err(fe1),
      .busy(busy1), .err_count(cnt1));

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Word-level model: collects accepted bits of the current frame as an integer.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         exp_dv[k] = 1'b0;
         exp_pe[k] = 1'b0;
         exp_fe[k] = 1'b0;
         if (rst) begin
            in_frame[k] = 1'b0;
            nbits[k] = 0; word[k] = 0; ones[k] = 0;
            exp_data[k] = 0; exp_cnt[k] = 0;
         end else if (x_valid) begin
            if (sof) begin
               exp_fe[k] = in_frame[k];
               in_frame[k] = 1'b1;
               nbits[k] = 1; word[k] = int'(x); ones[k] = int'(x);
            end else if (in_frame[k]) begin
               if (nbits[k] < 8) begin
                  word[k] = word[k] + (int'(x) << nbits[k]);
                  ones[k] = ones[k] + int'(x);
                  nbits[k]++;
               end else begin
                  exp_data[k] = word[k];
                  exp_dv[k] = 1'b1;
                  exp_pe[k] = ((ones[k] + int'(x)) % 2) != odd_mode[k];
                  if (exp_pe[k] && exp_cnt[k] < max_cnt[k]) exp_cnt[k]++;
                  in_frame[k] = 1'b0;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("u0.data_out",   int'(dout0), exp_data[0]);
         chk("u0.data_valid", int'(dv0),   int'(exp_dv[0]));
         chk("u0.parity_err", int'(pe0),   int'(exp_pe[0]));
         chk("u0.frame_err",  int'(fe0),   int'(exp_fe[0]));
         chk("u0.busy",       int'(busy0), int'(in_frame[0]));
         chk("u0.err_count",  int'(cnt0),  exp_cnt[0]);
         chk("u1.data_out",   int'(dout1), exp_data[1]);
         chk("u1.data_valid", int'(dv1),   int'(exp_dv[1]));
         chk("u1.parity_err", int'(pe1),   int'(exp_pe[1]));
         chk("u1.frame_err",  int'(fe1),   int'(exp_fe[1]));
         chk("u1.busy",       int'(busy1), int'(in_frame[1]));
         chk("u1.err_count",  int'(cnt1),  exp_cnt[1]);
         if (fe0) fe_seen++;
      end
   end

   // Idle gap cycles carry junk on x/sof with x_valid low; they must be ignored.
   task automatic send_bit(input logic b, input logic s, input int gaps);
      repeat (gaps) begin
         @(posedge clk); #1;
         x_valid = 1'b0; x = 1'($urandom); sof = 1'($urandom);
      end
      @(posedge clk); #1;
      x_valid = 1'b1; x = b; sof = s;
   endtask

   task automatic idle();
      @(posedge clk); #1;
      x_valid = 1'b0; sof = 1'b0;
   endtask

   task automatic frame(input logic [7:0] w, input logic p, input int maxgap);
      for (int i = 0; i < 8; i++)
         send_bit(w[i], (i == 0), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
      send_bit(p, 1'b0, (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1; x_valid = 1'b0; sof = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      int fe_before;
      logic [7:0] w;
      rst = 1'b1; x = 1'b0; x_valid = 1'b0; sof = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      rst = 1'b0;

      // even frame 0xA5, correct parity
      frame(8'hA5, 1'b0, 0);
      idle();
      @(negedge clk); #1;
      chk("t1.data", int'(dout0), 8'hA5);
      chk("t1.dv", int'(dv0), 1);
      chk("t1.pe", int'(pe0), 0);
      chk("t1.cnt", int'(cnt0), 0);

      // same frame, wrong parity
      frame(8'hA5, 1'b1, 0);
      idle();
      @(negedge clk); #1;
      chk("t2.data", int'(dout0), 8'hA5);
      chk("t2.pe", int'(pe0), 1);
      chk("t2.cnt", int'(cnt0), 1);

      // gapped frame 0x3C
      frame(8'h3C, 1'b0, 3);
      idle();
      @(negedge clk); #1;
      chk("t3.data", int'(dout0), 8'h3C);
      chk("t3.dv", int'(dv0), 1);
      chk("t3.pe", int'(pe0), 0);

      // aborted frame then 0x81
      fe_before = fe_seen;
      send_bit(1'b1, 1'b1, 0);
      send_bit(1'b1, 1'b0, 0);
      send_bit(1'b0, 1'b0, 1);
      send_bit(1'b1, 1'b0, 0);
      frame(8'h81, 1'b0, 0);
      idle();
      @(negedge clk); #1;
      chk("t4.data", int'(dout0), 8'h81);
      chk("t4.pe", int'(pe0), 0);
      chk("t4.fe_pulses", fe_seen - fe_before, 1);

      // reset mid-frame
      for (int i = 0; i < 5; i++) send_bit(1'b1, (i == 0), 0);
      @(posedge clk); #1;
      rst = 1'b1; x_valid = 1'b0; sof = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("t5.rst_data", int'(dout0), 0);
      chk("t5.rst_busy", int'(busy0), 0);
      chk("t5.rst_cnt", int'(cnt0), 0);
      chk("t5.rst_dv", int'(dv0), 0);
      frame(8'h0F, 1'b0, 0);
      idle();
      @(negedge clk); #1;
      chk("t5.data", int'(dout0), 8'h0F);
      chk("t5.pe", int'(pe0), 0);

      // odd mode with saturating 2-bit counter
      do_reset();
      frame(8'h01, 1'b0, 0);
      idle();
      @(negedge clk); #1;
      chk("t6.first_pe", int'(pe1), 0);
      chk("t6.first_cnt", int'(cnt1), 0);
      for (int n = 1; n <= 4; n++) begin
         frame(8'h00, 1'b0, 0);
         idle();
         @(negedge clk); #1;
         chk("t6.pe", int'(pe1), 1);
         chk("t6.cnt", int'(cnt1), (n < 3) ? n : 3);
      end

      // randomized traffic: gaps, stray bits, aborts, occasional resets
      for (int f = 0; f < 150; f++) begin
         w = 8'($urandom);
         if ($urandom_range(9, 0) == 0) send_bit(1'($urandom), 1'b0, int'($urandom_range(3, 0)));
         if ($urandom_range(7, 0) == 0) begin
            int n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++)
               send_bit(1'($urandom), (i == 0), int'($urandom_range(3, 0)));
         end
         if ($urandom_range(29, 0) == 0) do_reset();
         frame(w, 1'($urandom), 3);
         if ($urandom_range(1, 0) == 0) idle();
      end
      idle();
      repeat (3) @(posedge clk);
      @(negedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
